// File: rtl/pool_lane_engine_if.sv
// Streaming beat input and serialised writeback port of the pooling engine.
interface pool_lane_engine_if #(
    parameter int unsigned LANES  = 8,
    parameter int unsigned DATA_W = 16
);
    localparam int unsigned LW = $clog2(LANES);

    logic                    in_valid;
    logic                    in_ready;
    logic [LANES*DATA_W-1:0] in_data;
    logic                    out_valid;
    logic                    out_ready;
    logic [DATA_W-1:0]       out_data;
    logic [LW-1:0]           out_lane;

    // Source of beats / sink of results
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_lane
    );

    // Pooling engine side
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_lane
    );
endinterface

// File: rtl/pool_lane_engine.sv
// Pooling engine: reduces kernel windows of LANES-wide signed beats (max or
// rounded/saturated average) and serialises one result per lane.
// Optional macro POOL_TAIL_MASK_EN: skip lanes beyond i_channel in the last group.
module pool_lane_engine #(
    parameter int unsigned LANES  = 8,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned KS_W   = 8,
    parameter int unsigned CH_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              mode,
    input  logic [KS_W-1:0]   kernel_size,
    input  logic [DATA_W-1:0] recip,
    input  logic [7:0]        o_side,
    input  logic [CH_W-1:0]   i_channel,
    pool_lane_engine_if.slave bus,
    output logic              busy,
    output logic [7:0]        pix_count,
    output logic [CH_W-1:0]   ch_group,
    output logic              layer_done
);
    localparam int unsigned LW    = $clog2(LANES);
    localparam int unsigned ACC_W = DATA_W + KS_W;
    localparam int unsigned PW    = ACC_W + DATA_W + 1;
    localparam logic signed [PW-1:0] SAT_MAX = {{(PW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [PW-1:0] SAT_MIN = ~SAT_MAX;
    localparam logic signed [PW-1:0] RND     = {{(PW-DATA_W+1){1'b0}}, 1'b1, {(DATA_W-2){1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_ACCUM, S_SCALE, S_DRAIN, S_NEXT, S_DONE} state_t;

    state_t                  r_state, w_state_nxt;
    logic                    r_mode;
    logic [KS_W-1:0]         r_ks, r_beat;
    logic [DATA_W-1:0]       r_recip;
    logic [7:0]              r_oside, r_pix;
    logic [CH_W-1:0]         r_ich, r_grp;
    logic signed [ACC_W-1:0] r_acc [LANES];
    logic [DATA_W-1:0]       r_buf [LANES];
    logic                    r_in_ready, r_out_valid, r_busy, r_done;
    logic [DATA_W-1:0]       r_out_data;
    logic [LW-1:0]           r_lane;

    logic [KS_W-1:0]         w_k;
    logic [7:0]              w_oside;
    logic                    w_beat_fire, w_last_beat, w_out_fire, w_last_word;
    logic                    w_pix_more, w_grp_end;
    logic [CH_W:0]           w_grp_nxt;
    logic [LW-1:0]           w_last_lane;
    logic signed [ACC_W-1:0] w_samp  [LANES];
    logic signed [PW-1:0]    w_prod  [LANES];
    logic signed [PW-1:0]    w_shift [LANES];
    logic [DATA_W-1:0]       w_res   [LANES];

    assign w_k         = (r_ks == '0) ? KS_W'(1) : r_ks;
    assign w_oside     = (r_oside == 8'd0) ? 8'd1 : r_oside;
    assign w_beat_fire = (r_state == S_ACCUM) && r_in_ready && bus.in_valid;
    assign w_last_beat = ({1'b0, r_beat} + (KS_W+1)'(1)) == {1'b0, w_k};
    assign w_out_fire  = (r_state == S_DRAIN) && r_out_valid && bus.out_ready;
    assign w_last_word = w_out_fire && (r_lane == w_last_lane);
    assign w_pix_more  = ({1'b0, r_pix} + 9'd1) < {1'b0, w_oside};
    assign w_grp_nxt   = {1'b0, r_grp} + (CH_W+1)'(LANES);
    assign w_grp_end   = w_grp_nxt >= {1'b0, r_ich};

`ifdef POOL_TAIL_MASK_EN
    // Last emitted lane shrinks to the real channel count in the final group
    logic [CH_W:0] w_rem;
    assign w_rem       = {1'b0, r_ich} - {1'b0, r_grp};
    assign w_last_lane = ((r_ich != '0) && (w_rem < (CH_W+1)'(LANES)))
                         ? LW'(w_rem - (CH_W+1)'(1)) : LW'(LANES-1);
`else
    assign w_last_lane = LW'(LANES-1);
`endif

    // Per-lane sample extension and average scaling: round half up, then saturate
    always_comb begin
        for (int unsigned l = 0; l < LANES; l++) begin
            w_samp[l]  = ACC_W'($signed(bus.in_data[l*DATA_W +: DATA_W]));
            w_prod[l]  = PW'(r_acc[l]) * PW'($signed({1'b0, r_recip}));
            w_shift[l] = (w_prod[l] + RND) >>> (DATA_W-1);
            if (!r_mode)
                w_res[l] = r_acc[l][DATA_W-1:0];
            else if (w_shift[l] > SAT_MAX)
                w_res[l] = SAT_MAX[DATA_W-1:0];
            else if (w_shift[l] < SAT_MIN)
                w_res[l] = SAT_MIN[DATA_W-1:0];
            else
                w_res[l] = w_shift[l][DATA_W-1:0];
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_ACCUM;
            S_ACCUM: if (w_beat_fire && w_last_beat) w_state_nxt = S_SCALE;
            S_SCALE: w_state_nxt = S_DRAIN;
            S_DRAIN: if (w_last_word) w_state_nxt = S_NEXT;
            S_NEXT:  w_state_nxt = (!w_pix_more && w_grp_end) ? S_DONE : S_ACCUM;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath, counters and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode      <= 1'b0;
            r_ks        <= '0;
            r_beat      <= '0;
            r_recip     <= '0;
            r_oside     <= '0;
            r_pix       <= '0;
            r_ich       <= '0;
            r_grp       <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_out_data  <= '0;
            r_lane      <= '0;
            for (int unsigned l = 0; l < LANES; l++) begin
                r_acc[l] <= '0;
                r_buf[l] <= '0;
            end
        end else begin
            r_in_ready  <= (w_state_nxt == S_ACCUM);
            r_out_valid <= (w_state_nxt == S_DRAIN);
            r_busy      <= (w_state_nxt != S_IDLE);
            r_done      <= (w_state_nxt == S_DONE);
            case (r_state)
                S_IDLE: if (start) begin
                    r_mode  <= mode;
                    r_ks    <= kernel_size;
                    r_recip <= recip;
                    r_oside <= o_side;
                    r_ich   <= i_channel;
                    r_pix   <= '0;
                    r_grp   <= '0;
                    r_beat  <= '0;
                end
                S_ACCUM: if (w_beat_fire) begin
                    r_beat <= w_last_beat ? '0 : r_beat + KS_W'(1);
                    for (int unsigned l = 0; l < LANES; l++) begin
                        if (r_beat == '0)
                            r_acc[l] <= w_samp[l];
                        else if (r_mode)
                            r_acc[l] <= r_acc[l] + w_samp[l];
                        else if (w_samp[l] > r_acc[l])
                            r_acc[l] <= w_samp[l];
                    end
                end
                S_SCALE: begin
                    for (int unsigned l = 0; l < LANES; l++) r_buf[l] <= w_res[l];
                    r_out_data <= w_res[0];
                    r_lane     <= '0;
                end
                S_DRAIN: if (w_out_fire && !w_last_word) begin
                    r_lane     <= r_lane + LW'(1);
                    r_out_data <= r_buf[r_lane + LW'(1)];
                end
                S_NEXT: begin
                    if (w_pix_more) begin
                        r_pix <= r_pix + 8'd1;
                    end else begin
                        r_pix <= '0;
                        r_grp <= w_grp_nxt[CH_W-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_lane  = r_lane;
    assign busy          = r_busy;
    assign pix_count     = r_pix;
    assign ch_group      = r_grp;
    assign layer_done    = r_done;
endmodule

// File: tb/tb_pool_lane_engine.sv
// Bench for pool_lane_engine: table vectors, corner sequences, random layers
// against a window-level arithmetic model.
module tb_pool_lane_engine;
    localparam int unsigned LANES  = 8;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned KS_W   = 8;
    localparam int unsigned CH_W   = 16;

    typedef logic [LANES*DATA_W-1:0] beat_t;
    typedef struct { logic [15:0] data; int lane; int pix; int grp; } word_t;
    typedef struct packed {
        logic        md;
        logic [7:0]  ks;
        logic [15:0] rc;
        logic [15:0] b0, b1, b2, b3;
        logic [15:0] exp;
    } vec_t;

    logic clk = 1'b0, rst_n = 1'b1, start = 1'b0, mode = 1'b0;
    logic [KS_W-1:0]   kernel_size = '0;
    logic [DATA_W-1:0] recip = '0;
    logic [7:0]        o_side = '0;
    logic [CH_W-1:0]   i_channel = '0;
    logic              busy, layer_done;
    logic [7:0]        pix_count;
    logic [CH_W-1:0]   ch_group;

    pool_lane_engine_if #(.LANES(LANES), .DATA_W(DATA_W)) bus ();

    pool_lane_engine #(.LANES(LANES), .DATA_W(DATA_W), .KS_W(KS_W), .CH_W(CH_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
        .kernel_size(kernel_size), .recip(recip), .o_side(o_side), .i_channel(i_channel),
        .bus(bus), .busy(busy), .pix_count(pix_count), .ch_group(ch_group),
        .layer_done(layer_done)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    beat_t beats[$];
    word_t expq[$];
    bit          c_mode;
    logic [7:0]  c_ks, c_oside;
    logic [15:0] c_recip, c_ich;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Window result from the arithmetic definition of max / rounded average
    function automatic logic [15:0] ref_pool(input bit md, input int vals[$], input int rc);
        longint acc, q;
        if (!md) begin
            acc = vals[0];
            foreach (vals[i]) if (vals[i] > acc) acc = vals[i];
            return 16'(acc);
        end
        acc = 0;
        foreach (vals[i]) acc += vals[i];
        q = (acc * rc + 16384) >>> 15;
        if (q > 32767) q = 32767;
        if (q < -32768) q = -32768;
        return 16'(q);
    endfunction

    function automatic logic [15:0] rnd_sample();
        int r = $urandom_range(0, 9);
        if (r == 0) return 16'h7FFF;
        if (r == 1) return 16'h8000;
        return 16'($urandom);
    endfunction

    // Random beats for a whole layer plus the expected writeback stream
    task automatic gen_layer();
        int k  = (c_ks == 0) ? 1 : int'(c_ks);
        int os = (c_oside == 0) ? 1 : int'(c_oside);
        int ng = (c_ich == 0) ? 1 : (int'(c_ich) + LANES - 1) / LANES;
        for (int g = 0; g < ng; g++) begin
            for (int p = 0; p < os; p++) begin
                beat_t wb[$];
                int nl;
                wb.delete();
                for (int b = 0; b < k; b++) begin
                    beat_t bt;
                    for (int l = 0; l < LANES; l++) bt[l*16 +: 16] = rnd_sample();
                    wb.push_back(bt);
                    beats.push_back(bt);
                end
                nl = LANES;
`ifdef POOL_TAIL_MASK_EN
                if (c_ich != 0 && int'(c_ich) - g*LANES < LANES) nl = int'(c_ich) - g*LANES;
`endif
                for (int l = 0; l < nl; l++) begin
                    int q[$];
                    q.delete();
                    foreach (wb[b]) q.push_back(int'($signed(wb[b][l*16 +: 16])));
                    expq.push_back('{ref_pool(c_mode, q, int'(c_recip)), l, p, g*LANES});
                end
            end
        end
    endtask

    // Start a layer, feed beats, consume and check words until layer completes
    task automatic run_layer(input int stall_lane, input int abort_lane, input bit mid_start,
                             input int vpct, input int rpct);
        int cyc = 0, dcnt = 0, stalled = 0, since = 0;
        bit pv = 0, pr = 0, hold = 0, prev_ov = 0, fin = 0, rdy;
        logic [15:0] hd;
        logic [2:0]  hl;
        word_t w;
        @(negedge clk);
        mode = c_mode; kernel_size = c_ks; recip = c_recip; o_side = c_oside; i_channel = c_ich;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        while (!fin) begin
            since++;
            if (pv && pr) begin
                void'(beats.pop_front());
                since = 0;
            end
            if (hold) begin
                chk("stall_valid", bus.out_valid, 1);
                chk("stall_data", bus.out_data, hd);
                chk("stall_lane", bus.out_lane, hl);
            end
            if (bus.out_valid && !prev_ov) chk("lane0_latency", since, 1);
            if (bus.out_valid) chk("in_ready_while_drain", bus.in_ready, 0);
            if (abort_lane >= 0 && bus.out_valid && int'(bus.out_lane) == abort_lane) begin
                rst_n = 1'b0;
                #1;
                chk("rst_out_valid", bus.out_valid, 0);
                chk("rst_in_ready", bus.in_ready, 0);
                chk("rst_out_data", bus.out_data, 0);
                chk("rst_out_lane", bus.out_lane, 0);
                chk("rst_busy", busy, 0);
                chk("rst_pix", pix_count, 0);
                chk("rst_grp", ch_group, 0);
                chk("rst_done", layer_done, 0);
                beats.delete();
                expq.delete();
                bus.in_valid = 1'b0;
                bus.out_ready = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            rdy = ($urandom_range(0, 99) < rpct);
            if (stall_lane >= 0 && bus.out_valid && int'(bus.out_lane) == stall_lane && stalled < 5) begin
                rdy = 1'b0;
                stalled++;
            end
            bus.out_ready = rdy;
            hold = bus.out_valid && !rdy;
            hd = bus.out_data;
            hl = bus.out_lane;
            if (bus.out_valid && rdy) begin
                if (expq.size() == 0) begin
                    chk("extra_word", 1, 0);
                end else begin
                    w = expq.pop_front();
                    chk("out_data", bus.out_data, w.data);
                    chk("out_lane", bus.out_lane, w.lane);
                    chk("pix_count", pix_count, w.pix);
                    chk("ch_group", ch_group, w.grp);
                end
            end
            if (layer_done) dcnt++;
            if (mid_start && cyc == 3) begin
                start = 1'b1; mode = ~c_mode; kernel_size = c_ks + 8'd1;
                o_side = 8'd5; i_channel = 16'd100;
            end else begin
                start = 1'b0;
            end
            pv = (beats.size() > 0) && ($urandom_range(0, 99) < vpct);
            bus.in_valid = pv;
            bus.in_data = (beats.size() > 0) ? beats[0] : {4{$urandom}};
            pr = bus.in_ready;
            prev_ov = bus.out_valid;
            if (dcnt > 0 && !busy) fin = 1;
            cyc++;
            if (cyc > 4000) begin
                chk("layer_timeout", 1, 0);
                fin = 1;
            end
            if (!fin) @(negedge clk);
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        chk("layer_done_pulses", dcnt, 1);
        chk("beats_left", beats.size(), 0);
        chk("words_left", expq.size(), 0);
        chk("idle_after_done", busy, 0);
    endtask

    function automatic vec_t mkv(input bit md, input int ks, input int rc,
                                 input int b0, input int b1, input int b2, input int b3,
                                 input int ex);
        vec_t v;
        v.md = md; v.ks = 8'(ks); v.rc = 16'(rc);
        v.b0 = 16'(b0); v.b1 = 16'(b1); v.b2 = 16'(b2); v.b3 = 16'(b3);
        v.exp = 16'(ex);
        return v;
    endfunction

    vec_t tbl[9];

    initial begin
        tbl[0] = mkv(0, 4, 0,      -3,     7,  2, -9,     7);
        tbl[1] = mkv(1, 4, 16'h2000, 100, 200, 300, 400, 250);
        tbl[2] = mkv(1, 4, 16'h2000, -1,  -1, -1, -2,    -1);
        tbl[3] = mkv(1, 2, 16'h7FFF, 16'h7FFF, 16'h7FFF, 0, 0, 16'h7FFF);
        tbl[4] = mkv(1, 2, 16'h7FFF, 16'h8000, 16'h8000, 0, 0, 16'h8000);
        tbl[5] = mkv(0, 1, 0, 16'h8000, 0, 0, 0, 16'h8000);
        tbl[6] = mkv(0, 0, 0, 123, 0, 0, 0, 123);
        tbl[7] = mkv(0, 4, 0, -5, -2, -7, -3, -2);
        tbl[8] = mkv(1, 3, 16'h2AAB, 3, 3, 3, 0, 3);

        bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
        #2 rst_n = 1'b0;
        #3;
        chk("reset_busy", busy, 0);
        chk("reset_in_ready", bus.in_ready, 0);
        chk("reset_out_valid", bus.out_valid, 0);
        chk("reset_out_data", bus.out_data, 0);
        chk("reset_done", layer_done, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single-window vectors, every lane fed the same samples
        for (int t = 0; t < 9; t++) begin
            int k;
            logic [15:0] bv [4];
            c_mode = tbl[t].md; c_ks = tbl[t].ks; c_recip = tbl[t].rc;
            c_oside = 8'd1; c_ich = 16'd8;
            k = (c_ks == 0) ? 1 : int'(c_ks);
            bv[0] = tbl[t].b0; bv[1] = tbl[t].b1; bv[2] = tbl[t].b2; bv[3] = tbl[t].b3;
            for (int b = 0; b < k; b++) beats.push_back({LANES{bv[b]}});
            for (int l = 0; l < LANES; l++) expq.push_back('{tbl[t].exp, l, 0, 0});
            run_layer(-1, -1, 1'b0, 70, 80);
        end

        // Pixel / channel-group counters across 9 windows
        c_mode = 1'b1; c_ks = 8'd4; c_recip = 16'h2000; c_oside = 8'd3; c_ich = 16'd20;
        gen_layer();
        run_layer(-1, -1, 1'b0, 80, 70);

        // Backpressure on lane 3, everything else always ready
        c_mode = 1'b0; c_ks = 8'd4; c_oside = 8'd1; c_ich = 16'd8;
        gen_layer();
        run_layer(3, -1, 1'b0, 100, 100);

        // Start pulse while busy must be ignored
        c_mode = 1'b1; c_ks = 8'd2; c_recip = 16'h4000; c_oside = 8'd2; c_ich = 16'd0;
        gen_layer();
        run_layer(-1, -1, 1'b1, 60, 60);

        // Reset mid-drain, then a clean layer
        c_mode = 1'b0; c_ks = 8'd3; c_oside = 8'd1; c_ich = 16'd8;
        gen_layer();
        run_layer(-1, 5, 1'b0, 100, 100);
        c_mode = 1'b1; c_ks = 8'd3; c_recip = 16'h2AAB; c_oside = 8'd2; c_ich = 16'd12;
        gen_layer();
        run_layer(-1, -1, 1'b0, 90, 90);

        // Random layers
        for (int n = 0; n < 15; n++) begin
            c_mode  = 1'($urandom);
            c_ks    = 8'($urandom_range(0, 5));
            c_recip = ($urandom_range(0, 3) == 0) ? 16'($urandom)
                    : 16'((c_ks == 0) ? 32767 : ((32768 / int'(c_ks) > 32767) ? 32767 : 32768 / int'(c_ks)));
            c_oside = 8'($urandom_range(0, 3));
            c_ich   = 16'($urandom_range(0, 24));
            gen_layer();
            run_layer(-1, -1, 1'b0, $urandom_range(40, 100), $urandom_range(30, 100));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pool_lane_engine.md
Name: pool_lane_engine

Overview:
- Parametrised pooling engine; successor to the fixed-width maxpool/avepool path of the layer engine.
- Reduces a kernel window of LANES-wide signed fixed-point beats to one result per lane.
- Max and average modes; average uses a reciprocal multiply with rounding and saturation.
- Serialises results lane by lane on a ready/valid writeback port, with pixel and channel-group counters and a layer-done indication.

Parameters:
- LANES, 8, channels processed in parallel per beat (power of two, 2..32)
- DATA_W, 16, signed two's-complement sample width
- KS_W, 8, width of kernel_size and of the window beat counter
- CH_W, 16, width of the channel count and channel-group counter

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle layer start pulse; ignored outside IDLE
- mode  in  1  0 = max pool, 1 = average pool; sampled at start
- kernel_size  in  KS_W  beats per window (k*k); 0 treated as 1; sampled at start
- recip  in  DATA_W  unsigned Q0.(DATA_W-1) value of 1/kernel_size; sampled at start
- o_side  in  8  output pixels per channel group; 0 treated as 1; sampled at start
- i_channel  in  CH_W  total channels; sampled at start
- in_valid  in  1  input beat valid
- in_ready  out  1  engine accepts a beat
- in_data  in  LANES*DATA_W  lane i at bits [i*DATA_W +: DATA_W]
- out_valid  out  1  writeback word valid
- out_ready  in  1  writeback sink ready
- out_data  out  DATA_W  pooled result
- out_lane  out  clog2(LANES)  lane index of out_data
- busy  out  1  high in every state except IDLE
- pix_count  out  8  current pixel index within the channel group
- ch_group  out  CH_W  base channel of the current group
- layer_done  out  1  one-cycle pulse when the layer completes

Behaviour:
- Reset (async, rst_n low): state IDLE; every output and register 0.
- Reset mid-operation aborts immediately; no partial output.
- States: IDLE, ACCUM, SCALE, DRAIN, NEXT, DONE.
- IDLE:
  - start latches configuration; pix_count = 0, ch_group = 0, beat counter = 0.
  - Next state ACCUM.
- ACCUM:
  - in_ready = 1 (only in this state); a beat transfers when in_valid && in_ready.
  - Max mode: first beat loads the per-lane accumulator; later beats keep the signed maximum.
  - Average mode: per-lane accumulator of DATA_W+KS_W bits, cleared at window start; adds the sign-extended sample.
  - On the kernel_size-th accepted beat: go to SCALE; in_ready drops the next cycle.
- SCALE (one cycle):
  - Max mode: result = accumulator.
  - Average mode: product = acc * recip (signed x unsigned); add 2^(DATA_W-2), arithmetic-shift right by DATA_W-1; saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - Results are registered into the lane result buffer.
- DRAIN:
  - Emits lanes 0..last in order.
  - out_valid is held until out_ready; out_data and out_lane stay stable while stalled.
  - A handshake advances out_lane; after the last lane's handshake go to NEXT; out_valid deasserts the following cycle.
- NEXT (one cycle):
  - If pix_count+1 < o_side: pix_count++, go to ACCUM.
  - Else: pix_count = 0 and ch_group += LANES. If the new ch_group >= i_channel go to DONE, otherwise ACCUM.
- DONE: layer_done = 1 for exactly one cycle; go to IDLE.
- Latency: last window beat accepted in cycle t; SCALE in t+1; out_valid for lane 0 in t+2.
- Boundary conditions:
  - in_valid while not in ACCUM is not consumed.
  - start while busy is ignored.
  - out_ready high before out_valid has no effect.
  - i_channel = 0 behaves as one group.
  - Counter arithmetic uses full-width compares with no wrap.

Optional Feature:
- Macro: POOL_TAIL_MASK_EN.
- Defined: in the final channel group, only lanes 0..(i_channel - ch_group - 1) are emitted, so DRAIN ends early when i_channel is not a multiple of LANES. Masked lanes are never presented.
- Undefined: all LANES words are emitted for every group; tail lanes carry whatever the input supplied.

Test Plan:
- Max mode, LANES=8, kernel_size=4, o_side=1, i_channel=8. Lane 0 beats -3, 7, 2, -9 -> out_data lane 0 = 7. Eight words total, then one layer_done pulse.
- Average mode, kernel_size=4, recip=0x2000 (0.25). Lane 1 beats 100, 200, 300, 400 -> 250. Lane 2 beats -1, -1, -1, -2 -> -1 (round-half-up).
- Average saturation: kernel_size=2, recip=0x7FFF, beats 0x7FFF, 0x7FFF -> 0x7FFF. Beats 0x8000, 0x8000 -> 0x8000.
- Backpressure: out_ready low for 5 cycles during lane 3 -> out_valid, out_data and out_lane stable throughout; no word lost or duplicated; in_ready stays 0.
- Counters: o_side=3, i_channel=20, LANES=8 -> 9 windows; ch_group takes 0, 8, 16. With POOL_TAIL_MASK_EN the last group emits 4 words per pixel. layer_done fires once.
- Async reset asserted mid-DRAIN at lane 5 -> all outputs 0 immediately. A following start runs a clean layer.
